// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle datapath controller for a MIPS-lite subset
module multicycle_ctrl #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_ld,
  output logic           ir_ld,
  output logic           mdr_ld,
  output logic           a_ld,
  output logic           b_ld,
  output logic           aluout_ld,
  output logic           mem_read,
  output logic           mem_write,
  output logic           iord,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [2:0]     alu_ctl,
  output logic [1:0]     pc_src,
  output logic           instr_done,
  output logic           illegal
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);

  localparam logic [OPW-1:0] FN_ADD = OPW'(6'b100000);
  localparam logic [OPW-1:0] FN_SUB = OPW'(6'b100010);
  localparam logic [OPW-1:0] FN_AND = OPW'(6'b100100);
  localparam logic [OPW-1:0] FN_OR  = OPW'(6'b100101);
  localparam logic [OPW-1:0] FN_SLT = OPW'(6'b101010);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXE, S_RTWB, S_IEXE, S_IWB, S_BEQ, S_JMP
  } state_t;

  state_t state, state_nx;

  // State register; reset drops straight into RST so every strobe clears at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RST;
    else      state <= state_nx;
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_nx   = state;
    pc_ld      = 1'b0;
    ir_ld      = 1'b0;
    mdr_ld     = 1'b0;
    a_ld       = 1'b0;
    b_ld       = 1'b0;
    aluout_ld  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = 3'b010;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_RST: begin
        alu_ctl  = 3'b000;
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_ld    = 1'b1;
          pc_ld    = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is dispatched
        a_ld      = 1'b1;
        b_ld      = 1'b1;
        aluout_ld = 1'b1;
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_RTEXE;
          OP_BEQ:       state_nx = S_BEQ;
          OP_J:         state_nx = S_JMP;
          OP_ADDI:      state_nx = S_IEXE;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_nx   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluout_ld = 1'b1;
        state_nx  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          mdr_ld   = 1'b1;
          state_nx = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_nx   = S_FETCH;
        end
      end
      S_RTEXE: begin
        alu_src_a = 1'b1;
        aluout_ld = 1'b1;
        state_nx  = S_RTWB;
        case (funct)
          FN_ADD: alu_ctl = 3'b010;
          FN_SUB: alu_ctl = 3'b110;
          FN_AND: alu_ctl = 3'b000;
          FN_OR:  alu_ctl = 3'b001;
          FN_SLT: alu_ctl = 3'b111;
          default: begin
            aluout_ld  = 1'b0;
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_nx   = S_FETCH;
          end
        endcase
      end
      S_RTWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluout_ld = 1'b1;
        state_nx  = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_ctl    = 3'b110;
        pc_src     = 2'b01;
        pc_ld      = zero;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_JMP: begin
        pc_src     = 2'b10;
        pc_ld      = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_RST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_ld, ir_ld, mdr_ld, a_ld, b_ld, aluout_ld;
    logic       mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic [1:0] pc_src;
    logic       instr_done, illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_ld, ir_ld, mdr_ld, a_ld, b_ld, aluout_ld;
  logic       mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctl;
  logic [1:0] pc_src;
  logic       instr_done, illegal;

  outs_t act;
  outs_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  multicycle_ctrl #(.OPW(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_ld(pc_ld), .ir_ld(ir_ld), .mdr_ld(mdr_ld),
    .a_ld(a_ld), .b_ld(b_ld), .aluout_ld(aluout_ld), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctl(alu_ctl), .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal)
  );

  assign act = {pc_ld, ir_ld, mdr_ld, a_ld, b_ld, aluout_ld, mem_read, mem_write, iord,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctl, pc_src,
                instr_done, illegal};

  always #5 clk = ~clk;

  // Expected output vectors, written out by hand for each controller state
  function automatic outs_t e_zero();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t e_base();
    outs_t o = '0;
    o.alu_ctl = 3'b010;
    return o;
  endfunction
  function automatic outs_t e_fetch(bit rdy);
    outs_t o = e_base();
    o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_ld = rdy; o.pc_ld = rdy;
    return o;
  endfunction
  function automatic outs_t e_decode(bit ill);
    outs_t o = e_base();
    o.a_ld = 1; o.b_ld = 1; o.aluout_ld = 1; o.alu_src_b = 2'b11;
    o.illegal = ill; o.instr_done = ill;
    return o;
  endfunction
  function automatic outs_t e_adr();
    outs_t o = e_base();
    o.alu_src_a = 1; o.alu_src_b = 2'b10; o.aluout_ld = 1;
    return o;
  endfunction
  function automatic outs_t e_memrd(bit rdy);
    outs_t o = e_base();
    o.mem_read = 1; o.iord = 1; o.mdr_ld = rdy;
    return o;
  endfunction
  function automatic outs_t e_memwb();
    outs_t o = e_base();
    o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1;
    return o;
  endfunction
  function automatic outs_t e_memwr(bit rdy);
    outs_t o = e_base();
    o.mem_write = 1; o.iord = 1; o.instr_done = rdy;
    return o;
  endfunction
  function automatic outs_t e_rtexe(logic [2:0] ctl, bit ill);
    outs_t o = e_base();
    o.alu_src_a = 1; o.alu_ctl = ctl; o.aluout_ld = !ill;
    o.illegal = ill; o.instr_done = ill;
    return o;
  endfunction
  function automatic outs_t e_wb(bit rd);
    outs_t o = e_base();
    o.reg_write = 1; o.reg_dst = rd; o.instr_done = 1;
    return o;
  endfunction
  function automatic outs_t e_beq(bit z);
    outs_t o = e_base();
    o.alu_src_a = 1; o.alu_ctl = 3'b110; o.pc_src = 2'b01; o.pc_ld = z; o.instr_done = 1;
    return o;
  endfunction
  function automatic outs_t e_jmp();
    outs_t o = e_base();
    o.pc_src = 2'b10; o.pc_ld = 1; o.instr_done = 1;
    return o;
  endfunction

  // One controller cycle: drive inputs just after the edge and queue what must appear
  task automatic cyc(input outs_t e, input logic [5:0] op, input logic [5:0] fn,
                     input bit z, input bit rdy, input bit rstv, input string nm);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; zero = z; mem_ready = rdy; rst = rstv;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Immediate comparison of the current cycle's outputs
  task automatic check_now(input outs_t e, input string nm);
    #1;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s (immediate): actual %b required %b (t=%0t)", nm, act, e, $time);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: actual %b required %b (t=%0t)", n, act, e, $time);
      end
    end
  end

  logic [5:0] fn_tab [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
  logic [2:0] ctl_tab[4] = '{3'b010, 3'b110, 3'b000, 3'b001};

  initial begin
    for (int i = 0; i < 3; i++) cyc(e_zero(), 6'h00, 6'h00, 0, 1, 0, "reset_hold");
    check_now(e_zero(), "reset_state");
    cyc(e_zero(), 6'h00, 6'h00, 0, 1, 1, "reset_release");

    cyc(e_fetch(1), 6'b100011, 6'h00, 0, 1, 1, "lw_fetch");
    cyc(e_decode(0), 6'b100011, 6'h00, 0, 1, 1, "lw_decode");
    cyc(e_adr(), 6'b100011, 6'h00, 0, 1, 1, "lw_memadr");
    cyc(e_memrd(1), 6'b100011, 6'h00, 0, 1, 1, "lw_memrd");
    cyc(e_memwb(), 6'b100011, 6'h00, 0, 1, 1, "lw_memwb");

    cyc(e_fetch(1), 6'b101011, 6'h00, 0, 1, 1, "sw_fetch");
    cyc(e_decode(0), 6'b101011, 6'h00, 0, 1, 1, "sw_decode");
    cyc(e_adr(), 6'b101011, 6'h00, 0, 1, 1, "sw_memadr");
    cyc(e_memwr(0), 6'b101011, 6'h00, 0, 0, 1, "sw_memwr_wait1");
    cyc(e_memwr(0), 6'b101011, 6'h00, 0, 0, 1, "sw_memwr_wait2");
    cyc(e_memwr(1), 6'b101011, 6'h00, 0, 1, 1, "sw_memwr_done");
    check_now(e_memwr(1), "sw_wait_expired");

    cyc(e_fetch(1), 6'b000000, 6'b101010, 0, 1, 1, "slt_fetch");
    cyc(e_decode(0), 6'b000000, 6'b101010, 0, 1, 1, "slt_decode");
    cyc(e_rtexe(3'b111, 0), 6'b000000, 6'b101010, 0, 1, 1, "slt_rtexe");
    cyc(e_wb(1), 6'b000000, 6'b101010, 0, 1, 1, "slt_rtwb");

    for (int i = 0; i < 4; i++) begin
      cyc(e_fetch(1), 6'b000000, fn_tab[i], 0, 1, 1, "rt_fetch");
      cyc(e_decode(0), 6'b000000, fn_tab[i], 0, 1, 1, "rt_decode");
      cyc(e_rtexe(ctl_tab[i], 0), 6'b000000, fn_tab[i], 0, 1, 1, "rt_rtexe");
      cyc(e_wb(1), 6'b000000, fn_tab[i], 0, 1, 1, "rt_rtwb");
    end

    cyc(e_fetch(1), 6'b000000, 6'b000111, 0, 1, 1, "badfn_fetch");
    cyc(e_decode(0), 6'b000000, 6'b000111, 0, 1, 1, "badfn_decode");
    cyc(e_rtexe(3'b010, 1), 6'b000000, 6'b000111, 0, 1, 1, "badfn_rtexe");

    cyc(e_fetch(0), 6'b001000, 6'h00, 0, 0, 1, "addi_fetch_wait1");
    cyc(e_fetch(0), 6'b001000, 6'h00, 0, 0, 1, "addi_fetch_wait2");
    cyc(e_fetch(1), 6'b001000, 6'h00, 0, 1, 1, "addi_fetch");
    cyc(e_decode(0), 6'b001000, 6'h00, 0, 1, 1, "addi_decode");
    cyc(e_adr(), 6'b001000, 6'h00, 0, 1, 1, "addi_iexe");
    cyc(e_wb(0), 6'b001000, 6'h00, 0, 1, 1, "addi_iwb");

    cyc(e_fetch(1), 6'b000100, 6'h00, 0, 1, 1, "beq0_fetch");
    cyc(e_decode(0), 6'b000100, 6'h00, 0, 1, 1, "beq0_decode");
    cyc(e_beq(0), 6'b000100, 6'h00, 0, 1, 1, "beq0_beq");
    cyc(e_fetch(1), 6'b000100, 6'h00, 0, 1, 1, "beq1_fetch");
    cyc(e_decode(0), 6'b000100, 6'h00, 0, 1, 1, "beq1_decode");
    cyc(e_beq(1), 6'b000100, 6'h00, 1, 1, 1, "beq1_beq");

    cyc(e_fetch(1), 6'b000010, 6'h00, 0, 1, 1, "j_fetch");
    cyc(e_decode(0), 6'b000010, 6'h00, 0, 1, 1, "j_decode");
    cyc(e_jmp(), 6'b000010, 6'h00, 0, 1, 1, "j_jmp");

    cyc(e_fetch(1), 6'b111111, 6'h00, 0, 1, 1, "badop_fetch");
    cyc(e_decode(1), 6'b111111, 6'h00, 0, 1, 1, "badop_decode");

    cyc(e_fetch(1), 6'b100011, 6'h00, 0, 1, 1, "midrst_fetch");
    cyc(e_decode(0), 6'b100011, 6'h00, 0, 1, 1, "midrst_decode");
    cyc(e_adr(), 6'b100011, 6'h00, 0, 1, 1, "midrst_memadr");
    cyc(e_memrd(0), 6'b100011, 6'h00, 0, 0, 1, "midrst_memrd_wait");
    cyc(e_zero(), 6'b100011, 6'h00, 0, 0, 0, "midrst_assert");
    check_now(e_zero(), "midrst_outputs_cleared");
    cyc(e_zero(), 6'b100011, 6'h00, 0, 0, 0, "midrst_hold");
    cyc(e_zero(), 6'b000010, 6'h00, 0, 1, 1, "midrst_release");
    cyc(e_fetch(1), 6'b000010, 6'h00, 0, 1, 1, "restart_fetch");
    cyc(e_decode(0), 6'b000010, 6'h00, 0, 1, 1, "restart_decode");
    cyc(e_jmp(), 6'b000010, 6'h00, 0, 1, 1, "restart_jmp");

    @(posedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
